datapath_sequencer: RTL and testbench

- Hardware control unit that drives the register-transfer strobes of the datapath block. It replaces the hand-sequenced bench stimulus.
- Accepts one micro-operation per start handshake.
- Expands each micro-operation into one or more single-cycle strobe steps on the datapath control inputs.
- Signals completion with a one-cycle done pulse.

---
 rtl/datapath_sequencer_pkg.sv | 27 ++
 rtl/datapath_sequencer_seq_step_decode.sv | 51 +++++
 rtl/datapath_sequencer.sv | 133 +++++++++++++
 tb/tb_datapath_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, FSM states,
// strobe bundle and the default immediate width.
package datapath_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_MV   = 2'b10;
  localparam logic [1:0] OP_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic rz_out;
    logic ra_out;
    logic rb_out;
    logic ra_in;
    logic rb_in;
    logic rz_in;
  } strobe_t;

endpackage

// File: rtl/datapath_sequencer_seq_step_decode.sv
// Combinational map from (opcode, step index, gap flag) to the datapath
// strobe bundle and the immediate-bus selects.
module seq_step_decode
  import datapath_sequencer_pkg::*;
#(
  parameter int OP_WIDTH = 2
) (
  input  logic [OP_WIDTH-1:0] op,
  input  logic [1:0]          step,
  input  logic                gap,
  output strobe_t             strobe,
  output logic                sel_add_imm,
  output logic                sel_ra_imm
);

  logic [1:0] micro;

  always_comb begin
    strobe      = '0;
    sel_add_imm = 1'b0;
    sel_ra_imm  = 1'b0;
    micro       = 2'(op);
    // SEQ expands to LDI, ADDI, MV on successive steps
    if (2'(op) == OP_SEQ) begin
      case (step)
        2'd0:    micro = OP_LDI;
        2'd1:    micro = OP_ADDI;
        default: micro = OP_MV;
      endcase
    end
    if (!gap) begin
      case (micro)
        OP_LDI: begin
          strobe.ra_in = 1'b1;
          sel_ra_imm   = 1'b1;
        end
        OP_ADDI: begin
          strobe.ra_out = 1'b1;
          strobe.rz_in  = 1'b1;
          sel_add_imm   = 1'b1;
        end
        OP_MV: begin
          strobe.rz_out = 1'b1;
          strobe.rb_in  = 1'b1;
        end
        default: strobe = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-op sequencer driving datapath register-transfer strobes, all outputs
// registered. Define SEQ_GAP_CYCLE_EN to insert an idle gap between SEQ steps.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  busy,
  output logic                  done,
  output logic                  RZout,
  output logic                  RAout,
  output logic                  RBout,
  output logic                  RAin,
  output logic                  RBin,
  output logic                  RZin,
  output logic [DATA_WIDTH-1:0] AddImmediate,
  output logic [DATA_WIDTH-1:0] RegisterAImmediate
);

`ifdef SEQ_GAP_CYCLE_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [2:0]            slot_q, slot_d, slot_last;
  logic                  busy_q, busy_d, done_q, done_d;
  strobe_t               strobe_q, strobe_d, dec_strobe;
  logic [DATA_WIDTH-1:0] add_imm_q, add_imm_d, ra_imm_q, ra_imm_d;
  logic                  sel_add, sel_ra, dec_gap;
  logic [1:0]            dec_step;

  // Slots count strobe periods; with gaps enabled odd slots are the gaps
  always_comb begin
    slot_last = 3'd0;
    if (2'(op_q) == OP_SEQ) slot_last = GAP_EN ? 3'd4 : 3'd2;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    slot_d  = slot_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STEP;
          op_d    = op;
          imm_d   = imm;
          slot_d  = 3'd0;
        end
      end
      STEP: begin
        if (slot_q == slot_last) begin
          state_d = DONE;
          slot_d  = 3'd0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in the register
  // on the same edge the state advances
  always_comb begin
    dec_gap   = GAP_EN & slot_d[0];
    dec_step  = GAP_EN ? slot_d[2:1] : slot_d[1:0];
    busy_d    = (state_d == STEP);
    done_d    = (state_d == DONE);
    strobe_d  = busy_d ? dec_strobe : '0;
    add_imm_d = (busy_d && sel_add) ? imm_d : '0;
    ra_imm_d  = (busy_d && sel_ra) ? imm_d : '0;
  end

  seq_step_decode #(
    .OP_WIDTH(OP_WIDTH)
  ) u_decode (
    .op          (op_d),
    .step        (dec_step),
    .gap         (dec_gap),
    .strobe      (dec_strobe),
    .sel_add_imm (sel_add),
    .sel_ra_imm  (sel_ra)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      op_q      <= '0;
      imm_q     <= '0;
      slot_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= '0;
      add_imm_q <= '0;
      ra_imm_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      slot_q    <= slot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
      add_imm_q <= add_imm_d;
      ra_imm_q  <= ra_imm_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign RZout              = strobe_q.rz_out;
  assign RAout              = strobe_q.ra_out;
  assign RBout              = strobe_q.rb_out;
  assign RAin               = strobe_q.ra_in;
  assign RBin               = strobe_q.rb_in;
  assign RZin               = strobe_q.rz_in;
  assign AddImmediate       = add_imm_q;
  assign RegisterAImmediate = ra_imm_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: per-cycle strobe/immediate vectors,
// reset behaviour, ignored requests and bus exclusivity under held start.
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] imm;
  logic        busy, done, RZout, RAout, RBout, RAin, RBin, RZin;
  logic [31:0] AddImmediate, RegisterAImmediate;
  logic [7:0]  flags;

  int total = 0;
  int bad   = 0;

  datapath_sequencer dut (
    .clock              (clock),
    .clear              (clear),
    .start              (start),
    .op                 (op),
    .imm                (imm),
    .busy               (busy),
    .done               (done),
    .RZout              (RZout),
    .RAout              (RAout),
    .RBout              (RBout),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate)
  );

  always #5 clock = ~clock;

  // {busy, done, RZout, RAout, RBout, RAin, RBin, RZin}
  assign flags = {busy, done, RZout, RAout, RBout, RAin, RBin, RZin};

  localparam logic [7:0] F_IDLE = 8'h00;
  localparam logic [7:0] F_DONE = 8'h40;
  localparam logic [7:0] F_GAP  = 8'h80;
  localparam logic [7:0] F_LDI  = 8'h84;
  localparam logic [7:0] F_ADDI = 8'h91;
  localparam logic [7:0] F_MV   = 8'hA2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [7:0] f,
                            input logic [31:0] a, input logic [31:0] r);
    chk({tag, ".flags"}, 64'(flags), 64'(f));
    chk({tag, ".addimm"}, 64'(AddImmediate), 64'(a));
    chk({tag, ".raimm"}, 64'(RegisterAImmediate), 64'(r));
  endtask

  // Presents a request for one edge; on return the first step cycle is visible
  task automatic issue(input logic [1:0] o, input logic [31:0] i);
    start = 1'b1;
    op    = o;
    imm   = i;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input logic [31:0] i);
    expect_cyc({tag, ".c1"}, F_LDI, 32'h0, i);
    tick();
`ifdef SEQ_GAP_CYCLE_EN
    expect_cyc({tag, ".g1"}, F_GAP, 32'h0, 32'h0);
    tick();
`endif
    expect_cyc({tag, ".c2"}, F_ADDI, i, 32'h0);
    tick();
`ifdef SEQ_GAP_CYCLE_EN
    expect_cyc({tag, ".g2"}, F_GAP, 32'h0, 32'h0);
    tick();
`endif
    expect_cyc({tag, ".c3"}, F_MV, 32'h0, 32'h0);
    tick();
    expect_cyc({tag, ".done"}, F_DONE, 32'h0, 32'h0);
  endtask

  int   accepts;
  int   dones;
  logic prev_busy;

  initial begin
    clear = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    imm   = 32'h0;
    #2;
    expect_cyc("rst", F_IDLE, 32'h0, 32'h0);
    #21 clear = 1'b1;
    tick();
    expect_cyc("idle0", F_IDLE, 32'h0, 32'h0);

    // LDI
    issue(2'b00, 32'h5);
    expect_cyc("ldi.c1", F_LDI, 32'h0, 32'h5);
    tick();
    expect_cyc("ldi.done", F_DONE, 32'h0, 32'h0);
    tick();
    expect_cyc("ldi.idle", F_IDLE, 32'h0, 32'h0);

    // ADDI
    issue(2'b01, 32'h5);
    expect_cyc("addi.c1", F_ADDI, 32'h5, 32'h0);
    tick();
    expect_cyc("addi.done", F_DONE, 32'h0, 32'h0);
    tick();

    // MV
    issue(2'b10, 32'h1234_5678);
    expect_cyc("mv.c1", F_MV, 32'h0, 32'h0);
    tick();
    expect_cyc("mv.done", F_DONE, 32'h0, 32'h0);
    tick();

    // SEQ with small and full-width immediates
    issue(2'b11, 32'h5);
    expect_seq("seq5", 32'h5);
    tick();
    expect_cyc("seq5.idle", F_IDLE, 32'h0, 32'h0);
    issue(2'b11, 32'hDEAD_BEEF);
    expect_seq("seqff", 32'hDEAD_BEEF);
    tick();

    // Requests during STEP and DONE are dropped
    issue(2'b11, 32'h7);
    start = 1'b1;
    op    = 2'b00;
    imm   = 32'hFFFF_FFFF;
    expect_seq("ign", 32'h7);
    tick();
    start = 1'b0;
    expect_cyc("ign.idle", F_IDLE, 32'h0, 32'h0);
    tick();
    expect_cyc("ign.idle2", F_IDLE, 32'h0, 32'h0);

    // Reset in the middle of a SEQ
    issue(2'b11, 32'h9);
    tick();
    #2 clear = 1'b0;
    #1;
    expect_cyc("midrst", F_IDLE, 32'h0, 32'h0);
    #3 clear = 1'b1;
    tick();
    expect_cyc("midrst.a", F_IDLE, 32'h0, 32'h0);
    tick();
    expect_cyc("midrst.b", F_IDLE, 32'h0, 32'h0);

    // Random ops with start held high
    accepts   = 0;
    dones     = 0;
    prev_busy = 1'b0;
    start     = 1'b1;
    for (int c = 0; c < 200; c++) begin
      op  = 2'($urandom_range(0, 3));
      imm = $urandom;
      tick();
      chk("excl", 64'(($countones({RZout, RAout, RBout}) <= 1)), 64'd1);
      if (busy && !prev_busy) accepts++;
      if (done) dones++;
      prev_busy = busy;
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy && !prev_busy) accepts++;
      if (done) dones++;
      prev_busy = busy;
    end
    chk("rand.accepts", 64'((accepts > 20)), 64'd1);
    chk("rand.dones", 64'(dones), 64'(accepts));
    expect_cyc("rand.idle", F_IDLE, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
